// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx
// Description : Serial-in / parallel-out receiver. Serial bits are accepted
//               on a valid/ready handshake and assembled MSB first into
//               DATA_WIDTH-bit words. Completed words are buffered in a
//               FIFO_DEPTH-entry FIFO with a valid/ready output handshake.
//
//               Optional feature (macro SIPO_PARITY_EN): each word is
//               followed by one even-parity bit. Words with a parity error
//               are dropped, and perr_o pulses for one cycle.
//
// Ports       : clk_i    - clock, rising edge
//               rst_n_i  - asynchronous active-low reset
//               data_i   - serial data bit
//               valid_i  - data_i carries a valid bit
//               ready_o  - a serial bit is accepted this cycle (FIFO not full)
//               data_o   - parallel word at the FIFO head (0 when empty)
//               valid_o  - data_o is valid (FIFO not empty)
//               ready_i  - downstream accepts data_o
//               perr_o   - one-cycle parity-error pulse (0 without parity)
//
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_rx #(
    parameter int DATA_WIDTH = 8,   // bits per word, at least 2
    parameter int FIFO_DEPTH = 4    // power of 2, at least 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  perr_o
);

    localparam int c_CNT_W = $clog2(DATA_WIDTH);
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_AW:0]      c_PTR_ONE  = (c_AW + 1)'(1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [c_AW:0]           r_wr_ptr;
    logic [c_AW:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                  w_state_next;
    logic [c_CNT_W-1:0]      w_cnt_next;
    logic [DATA_WIDTH-1:0]   w_shift_next;
    logic [DATA_WIDTH-1:0]   w_shift_in;
    logic [DATA_WIDTH-1:0]   w_push_data;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_accept;
    logic                    w_full;
    logic                    w_empty;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // Both handshake outputs come straight from the pointer registers.
    assign ready_o  = ~w_full;
    assign valid_o  = ~w_empty;
    assign data_o   = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_accept = valid_i & ~w_full;
    assign w_pop    = ~w_empty & ready_i;

    // Shift left, new bit at LSB: the first bit ends up at the MSB.
    assign w_shift_in = (r_shift << 1) | {{(DATA_WIDTH-1){1'b0}}, data_i};

`ifdef SIPO_PARITY_EN
    logic r_perr;
    logic w_perr_next;
    assign perr_o = r_perr;
`else
    assign perr_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef SIPO_PARITY_EN
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            r_shift   <= w_shift_next;
`ifdef SIPO_PARITY_EN
            r_perr    <= w_perr_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_push       = 1'b0;
        w_push_data  = w_shift_in;
`ifdef SIPO_PARITY_EN
        w_perr_next  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_shift_next = w_shift_in;
                    w_cnt_next   = c_CNT_ONE;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_accept) begin
                    w_shift_next = w_shift_in;
                    if (r_bit_cnt == c_CNT_LAST) begin
                        w_cnt_next = '0;
`ifdef SIPO_PARITY_EN
                        // Hold the full word until its parity bit arrives.
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_IDLE;
                        w_push       = 1'b1;
                        w_shift_next = '0;
`endif
                    end else begin
                        w_cnt_next = r_bit_cnt + c_CNT_ONE;
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            S_PARITY: begin
                if (w_accept) begin
                    w_state_next = S_IDLE;
                    w_shift_next = '0;
                    w_push_data  = r_shift;
                    // Even parity: total ones including parity bit must be even.
                    if ((^r_shift) ^ data_i) begin
                        w_perr_next = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_shift_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO. A push is only possible when not full (accept is gated
    // by ready_o) and a pop only when not empty, so no overflow/underflow.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage needs no reset: data_o is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_push_data;
        end
    end

endmodule
`default_nettype wire

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: bits per parallel word.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: number of output buffer entries; it SHALL be a power of 2 and at least 2.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_i, input, 1 bit: serial data bit.
REQ-006 The block SHALL have port valid_i, input, 1 bit: data_i carries a valid bit.
REQ-007 The block SHALL have port ready_o, output, 1 bit: the block accepts a serial bit this cycle.
REQ-008 The block SHALL have port data_o, output, DATA_WIDTH bits: parallel word at the FIFO head.
REQ-009 The block SHALL have port valid_o, output, 1 bit: data_o is valid.
REQ-010 The block SHALL have port ready_i, input, 1 bit: downstream accepts data_o.
REQ-011 The block SHALL have port perr_o, output, 1 bit: one-cycle parity-error pulse.

Function
REQ-012 A serial bit SHALL be accepted on a rising edge where valid_i=1 and ready_o=1; no other edge changes the shift state.
REQ-013 Bits SHALL be assembled MSB first: the first accepted bit of a word lands in data_o[DATA_WIDTH-1].
REQ-014 The FSM SHALL have states: S_IDLE (0 bits held), S_SHIFT (1..DATA_WIDTH-1 bits held) and S_PARITY (word complete, parity bit expected; exists only when the macro is defined).
REQ-015 Transitions: S_IDLE->S_SHIFT on the first accepted bit; S_SHIFT stays until the DATA_WIDTH-th accepted bit; it then goes to S_PARITY (macro on) or to S_IDLE with a word push (macro off); S_PARITY->S_IDLE on the next accepted bit.
REQ-016 The bit counter SHALL count 0..DATA_WIDTH-1 and return to 0 on word completion; it SHALL never wrap otherwise.
REQ-017 The assembled word SHALL be written into the FIFO on the same edge that accepts its final bit (data bit, or parity bit when the macro is on).
REQ-018 valid_o SHALL equal "FIFO not empty"; data_o SHALL be the FIFO head and stay stable while valid_o=1 and ready_i=0.
REQ-019 The FIFO SHALL pop on an edge where valid_o=1 and ready_i=1.
REQ-020 Latency: valid_o SHALL rise one clock after the edge that accepts the final bit of a word into an empty FIFO.
REQ-021 ready_o SHALL be 0 when the FIFO is full, and 1 otherwise; it SHALL be derived from registered state only.
REQ-022 A simultaneous push and pop SHALL leave the entry count unchanged and preserve order; the FIFO SHALL never overflow or underflow.
REQ-023 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished with an extra pointer bit.
REQ-024 valid_i=0 mid-word SHALL hold the state and bit count indefinitely (no timeout).

Reset
REQ-025 rst_n_i=0 SHALL immediately force: S_IDLE, bit count 0, shift register 0, FIFO empty (pointers 0), valid_o=0, data_o=0, perr_o=0, ready_o=1.
REQ-026 Reset asserted mid-word SHALL discard the partial word and all buffered words.
REQ-027 Release of reset SHALL take effect at the first rising clock edge after rst_n_i=1.

Configuration
REQ-028 Macro SIPO_PARITY_EN, when defined, SHALL add one even-parity bit after each DATA_WIDTH data bits, accepted in S_PARITY.
REQ-029 With SIPO_PARITY_EN, a word whose ones count, including the parity bit, is odd SHALL be dropped (not pushed), and perr_o SHALL pulse high for exactly one cycle after the accepting edge.
REQ-030 Without SIPO_PARITY_EN, S_PARITY SHALL not exist, words SHALL be DATA_WIDTH bits, and perr_o SHALL be constant 0.

Verification
REQ-031 Reset, then serial 1,0,1,0,0,1,0,1 with valid_i=1 and ready_i=1 (macro off) -> data_o=8'hA5, valid_o high one cycle after the 8th bit, for one cycle.
REQ-032 With ready_i=0, push 5 words (8'h01..8'h05) -> ready_o falls after the 4th word; the 5th word's bits wait; raising ready_i -> data_o sequence 01,02,03,04,05 in order.
REQ-033 Apply valid_i toggling 1/0 on alternate cycles while sending 8'h3C -> data_o=8'h3C; bit count holds on idle cycles.
REQ-034 After 5 bits of a word, pulse rst_n_i low mid-cycle -> valid_o=0 and ready_o=1 at once; next 8 bits 8'hFF -> data_o=8'hFF.
REQ-035 Macro on: send 8'h0F plus parity 0 -> word pushed; send 8'h0F plus parity 1 -> no push, perr_o high exactly one cycle.
REQ-036 FIFO holds 3 words, ready_i=1, final bit of a 4th word accepted on the same edge as a pop -> count stays 3, order preserved.
